// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and event word layout for the PS/2 scan-code sequencer.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_KERR0 = 8'h00;
   localparam logic [7:0] PS2_KERR1 = 8'hFF;

   localparam int EVT_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } ps2_state_t;

   // Event word: {ext, brk, code[7:0]}
   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_evt_t;

   // Keyboard error/overrun bytes
   function automatic logic is_kerr(input logic [7:0] b);
      return (b == PS2_KERR0) || (b == PS2_KERR1);
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead synchronous FIFO holding decoded key events.
module ps2_evt_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             CLKOUT,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic             wr_en;
   logic             rd_en;

   // A full FIFO still accepts a write when the head leaves in the same cycle
   assign wr_en   = push && (!full || pop);
   assign rd_en   = pop && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rptr];

   // Storage write; cleared on reset so the head reads zero while empty
   always_ff @(posedge CLKOUT or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wptr] <= wr_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy
   always_ff @(posedge CLKOUT or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (rd_en) rptr <= rptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// Collapses E0/F0 prefix sequences into single key events, supervises the
// receiver with an inter-byte timeout, and queues events for the consumer.
module ps2_scan_ctrl
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 50000,
   parameter int TO_W        = 16
) (
   input  logic       CLKOUT,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_err,
   input  logic       ev_ready,
   output logic       ev_valid,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_break,
   output logic       ovf,
   output logic       seq_err,
   input  logic       clr_flags,
   output logic       busy
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   ps2_state_t      state, state_next;
   logic [TO_W-1:0] to_cnt;
   logic            push;
   ps2_evt_t        push_evt;
   ps2_evt_t        head_evt;
   logic            err_set;
   logic            ovf_set;
   logic            pop;
   logic            full;
   logic            empty;

   assign pop      = !empty && ev_ready;
   assign ev_valid = !empty;
   assign ev_code  = head_evt.code;
   assign ev_ext   = head_evt.ext;
   assign ev_break = head_evt.brk;
   assign busy     = (state != ST_IDLE);
   // Only a push that finds no room (and no departing head) is lost
   assign ovf_set  = push && full && !pop;

   // State register
   always_ff @(posedge CLKOUT or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next state, event push and error detection; rx_err overrides any byte
   always_comb begin
      state_next = state;
      push       = 1'b0;
      push_evt   = '0;
      err_set    = 1'b0;
      if (rx_err) begin
         state_next = ST_IDLE;
         err_set    = 1'b1;
      end else if (rx_valid) begin
         push_evt.code = rx_data;
         if (is_kerr(rx_data)) begin
            state_next = ST_IDLE;
            err_set    = 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (rx_data == PS2_EXT)      state_next = ST_EXT;
                  else if (rx_data == PS2_BRK) state_next = ST_BRK;
                  else                         push = 1'b1;
               end
               ST_EXT: begin
                  if (rx_data == PS2_BRK)      state_next = ST_EXT_BRK;
                  else if (rx_data == PS2_EXT) state_next = ST_EXT;
                  else begin
                     push         = 1'b1;
                     push_evt.ext = 1'b1;
                     state_next   = ST_IDLE;
                  end
               end
               ST_BRK, ST_EXT_BRK: begin
                  state_next = ST_IDLE;
                  if (rx_data == PS2_EXT || rx_data == PS2_BRK) begin
                     err_set = 1'b1;
                  end else begin
                     push         = 1'b1;
                     push_evt.ext = (state == ST_EXT_BRK);
                     push_evt.brk = 1'b1;
                  end
               end
               default: state_next = ST_IDLE;
            endcase
         end
      end else if (state != ST_IDLE && to_cnt == TO_LAST) begin
         state_next = ST_IDLE;
         err_set    = 1'b1;
      end
   end

   // Inter-byte timer: held at zero in IDLE, restarted by every byte
   always_ff @(posedge CLKOUT or negedge rst_n) begin
      if (!rst_n)                          to_cnt <= '0;
      else if (rx_valid || state == ST_IDLE) to_cnt <= '0;
      else                                 to_cnt <= to_cnt + 1'b1;
   end

   // Sticky flags; a set in the same cycle as clr_flags takes priority
   always_ff @(posedge CLKOUT or negedge rst_n) begin
      if (!rst_n) begin
         ovf     <= 1'b0;
         seq_err <= 1'b0;
      end else begin
         ovf     <= ovf_set | (ovf & ~clr_flags);
         seq_err <= err_set | (seq_err & ~clr_flags);
      end
   end

   ps2_evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLKOUT  (CLKOUT),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (push_evt),
      .pop     (pop),
      .rd_data (head_evt),
      .full    (full),
      .empty   (empty)
   );

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Directed self-checking bench for ps2_scan_ctrl.
module tb_ps2_scan_ctrl;

   localparam int TO_CYC = 20;

   logic       CLKOUT = 1'b0;
   logic       rst_n  = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_err = 1'b0;
   logic       ev_ready = 1'b0;
   logic       clr_flags = 1'b0;
   logic       ev_valid, ev_ext, ev_break, ovf, seq_err, busy;
   logic [7:0] ev_code;

   int pass_cnt  = 0;
   int total_cnt = 0;

   ps2_scan_ctrl #(
      .FIFO_DEPTH  (4),
      .TIMEOUT_CYC (TO_CYC),
      .TO_W        (16)
   ) dut (
      .CLKOUT    (CLKOUT),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_err    (rx_err),
      .ev_ready  (ev_ready),
      .ev_valid  (ev_valid),
      .ev_code   (ev_code),
      .ev_ext    (ev_ext),
      .ev_break  (ev_break),
      .ovf       (ovf),
      .seq_err   (seq_err),
      .clr_flags (clr_flags),
      .busy      (busy)
   );

   always #5 CLKOUT = ~CLKOUT;

   // All tasks start and end 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge CLKOUT); #1;
      rx_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      @(posedge CLKOUT); #1;
      clr_flags = 1'b0;
   endtask

   // Observe head {valid,ext,brk,code} then pop it
   task automatic pop_evt(output logic [10:0] obs);
      obs      = {ev_valid, ev_ext, ev_break, ev_code};
      ev_ready = 1'b1;
      @(posedge CLKOUT); #1;
      ev_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [6:0] obs;
      rst_n = 1'b0;
      #12;
      obs = {ev_valid, ev_ext, ev_break, ovf, seq_err, busy, |ev_code};
      total_cnt++;
      if (obs !== 7'b0) $display("FAIL reset_outputs got=%b exp=%b", obs, 7'b0);
      else pass_cnt++;
      @(negedge CLKOUT); rst_n = 1'b1;
      @(posedge CLKOUT); #1;
   endtask

   task automatic test_make_break();
      logic [10:0] obs;
      send_byte(8'h1C);
      total_cnt++;
      if ({busy, ev_valid} !== 2'b01) $display("FAIL mk_after_1c got=%b exp=01", {busy, ev_valid});
      else pass_cnt++;
      send_byte(8'hF0);
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL mk_busy_after_f0 got=%b exp=1", busy);
      else pass_cnt++;
      send_byte(8'h1C);
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL mk_busy_after_brk got=%b exp=0", busy);
      else pass_cnt++;
      pop_evt(obs);
      total_cnt++;
      if (obs !== 11'h41C) $display("FAIL mk_make_evt got=%h exp=%h", obs, 11'h41C);
      else pass_cnt++;
      pop_evt(obs);
      total_cnt++;
      if (obs !== 11'h51C) $display("FAIL mk_break_evt got=%h exp=%h", obs, 11'h51C);
      else pass_cnt++;
      total_cnt++;
      if ({ev_valid, seq_err} !== 2'b00) $display("FAIL mk_drained got=%b exp=00", {ev_valid, seq_err});
      else pass_cnt++;
   endtask

   task automatic test_ext();
      logic [10:0] obs;
      send_byte(8'hE0);
      total_cnt++;
      if ({busy, ev_valid} !== 2'b10) $display("FAIL ext_after_e0 got=%b exp=10", {busy, ev_valid});
      else pass_cnt++;
      rx_data  = 8'h75;
      rx_valid = 1'b1;
      #2;
      total_cnt++;
      if (ev_valid !== 1'b0) $display("FAIL ext_valid_early got=%b exp=0", ev_valid);
      else pass_cnt++;
      @(posedge CLKOUT); #1;
      rx_valid = 1'b0;
      total_cnt++;
      if (ev_valid !== 1'b1) $display("FAIL ext_valid_latency got=%b exp=1", ev_valid);
      else pass_cnt++;
      pop_evt(obs);
      total_cnt++;
      if (obs !== 11'h675) $display("FAIL ext_make_evt got=%h exp=%h", obs, 11'h675);
      else pass_cnt++;
      send_byte(8'hE0);
      send_byte(8'hF0);
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL ext_busy_e0f0 got=%b exp=1", busy);
      else pass_cnt++;
      send_byte(8'h75);
      pop_evt(obs);
      total_cnt++;
      if (obs !== 11'h775) $display("FAIL ext_break_evt got=%h exp=%h", obs, 11'h775);
      else pass_cnt++;
      total_cnt++;
      if ({busy, seq_err, ev_valid} !== 3'b000) $display("FAIL ext_end got=%b exp=000", {busy, seq_err, ev_valid});
      else pass_cnt++;
   endtask

   task automatic test_overflow();
      logic [10:0] obs;
      logic [7:0]  codes [5];
      codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
      ev_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(codes[i]);
      total_cnt++;
      if (ovf !== 1'b0) $display("FAIL ovf_at_four got=%b exp=0", ovf);
      else pass_cnt++;
      send_byte(codes[4]);
      total_cnt++;
      if (ovf !== 1'b1) $display("FAIL ovf_at_five got=%b exp=1", ovf);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         pop_evt(obs);
         total_cnt++;
         if (obs !== {3'b100, codes[i]}) $display("FAIL ovf_drain%0d got=%h exp=%h", i, obs, {3'b100, codes[i]});
         else pass_cnt++;
      end
      total_cnt++;
      if ({ev_valid, ovf} !== 2'b01) $display("FAIL ovf_empty got=%b exp=01", {ev_valid, ovf});
      else pass_cnt++;
      pulse_clr();
      total_cnt++;
      if (ovf !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", ovf);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      logic [10:0] obs;
      send_byte(8'hF0);
      repeat (TO_CYC / 2) @(posedge CLKOUT);
      #1;
      total_cnt++;
      if ({busy, seq_err} !== 2'b10) $display("FAIL to_midway got=%b exp=10", {busy, seq_err});
      else pass_cnt++;
      repeat (TO_CYC - TO_CYC / 2) @(posedge CLKOUT);
      #1;
      total_cnt++;
      if ({busy, seq_err, ev_valid} !== 3'b010) $display("FAIL to_expired got=%b exp=010", {busy, seq_err, ev_valid});
      else pass_cnt++;
      pulse_clr();
      send_byte(8'h1C);
      pop_evt(obs);
      total_cnt++;
      if (obs !== 11'h41C) $display("FAIL to_after_evt got=%h exp=%h", obs, 11'h41C);
      else pass_cnt++;
      total_cnt++;
      if (seq_err !== 1'b0) $display("FAIL to_no_err got=%b exp=0", seq_err);
      else pass_cnt++;
   endtask

   task automatic test_errors();
      logic [10:0] obs;
      send_byte(8'hE0);
      rx_err = 1'b1;
      @(posedge CLKOUT); #1;
      rx_err = 1'b0;
      total_cnt++;
      if ({busy, seq_err} !== 2'b01) $display("FAIL err_rx_err got=%b exp=01", {busy, seq_err});
      else pass_cnt++;
      send_byte(8'h74);
      pop_evt(obs);
      total_cnt++;
      if (obs !== 11'h474) $display("FAIL err_after_evt got=%h exp=%h", obs, 11'h474);
      else pass_cnt++;
      pulse_clr();
      send_byte(8'hFF);
      total_cnt++;
      if ({seq_err, ev_valid, busy} !== 3'b100) $display("FAIL err_kerr_ff got=%b exp=100", {seq_err, ev_valid, busy});
      else pass_cnt++;
      pulse_clr();
      // error wins over a byte in the same cycle
      rx_err = 1'b1;
      send_byte(8'h1C);
      rx_err = 1'b0;
      @(posedge CLKOUT); #1;
      total_cnt++;
      if ({seq_err, ev_valid} !== 2'b10) $display("FAIL err_vs_valid got=%b exp=10", {seq_err, ev_valid});
      else pass_cnt++;
      pulse_clr();
      // a new error set in the clr_flags cycle is kept
      send_byte(8'hE0);
      clr_flags = 1'b1;
      send_byte(8'h00);
      clr_flags = 1'b0;
      total_cnt++;
      if ({seq_err, busy, ev_valid} !== 3'b100) $display("FAIL err_set_wins got=%b exp=100", {seq_err, busy, ev_valid});
      else pass_cnt++;
      // prefix after F0 is an error, no event
      pulse_clr();
      send_byte(8'hF0);
      send_byte(8'hE0);
      total_cnt++;
      if ({seq_err, busy, ev_valid} !== 3'b100) $display("FAIL err_brk_prefix got=%b exp=100", {seq_err, busy, ev_valid});
      else pass_cnt++;
      pulse_clr();
   endtask

   task automatic test_back_to_back();
      logic [10:0] obs;
      logic [7:0]  codes [5];
      codes = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      for (int i = 0; i < 4; i++) send_byte(codes[i]);
      // push into full FIFO while the head leaves
      ev_ready = 1'b1;
      send_byte(codes[4]);
      ev_ready = 1'b0;
      total_cnt++;
      if ({ovf, ev_valid, ev_code} !== {2'b01, 8'h12}) $display("FAIL b2b_full_pp got=%h exp=%h", {ovf, ev_valid, ev_code}, {2'b01, 8'h12});
      else pass_cnt++;
      for (int i = 1; i < 5; i++) begin
         pop_evt(obs);
         total_cnt++;
         if (obs !== {3'b100, codes[i]}) $display("FAIL b2b_drain%0d got=%h exp=%h", i, obs, {3'b100, codes[i]});
         else pass_cnt++;
      end
      total_cnt++;
      if ({ev_valid, ovf} !== 2'b00) $display("FAIL b2b_empty got=%b exp=00", {ev_valid, ovf});
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      send_byte(8'h16);
      send_byte(8'hE0);
      send_byte(8'hF0);
      total_cnt++;
      if ({busy, ev_valid} !== 2'b11) $display("FAIL rst_pre got=%b exp=11", {busy, ev_valid});
      else pass_cnt++;
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({busy, ev_valid, ev_code} !== 10'b0) $display("FAIL rst_async got=%h exp=%h", {busy, ev_valid, ev_code}, 10'h0);
      else pass_cnt++;
      @(negedge CLKOUT); rst_n = 1'b1;
      @(posedge CLKOUT); #1;
      send_byte(8'h1C);
      total_cnt++;
      if ({busy, ev_valid, ev_break, ev_code} !== {3'b010, 8'h1C}) $display("FAIL rst_recover got=%h exp=%h", {busy, ev_valid, ev_break, ev_code}, {3'b010, 8'h1C});
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_make_break();
      test_ext();
      test_overflow();
      test_timeout();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
